uart_prog_loader: RTL

Upstream stage of the BIP core: consumes bytes from the UART receiver and writes a program image into BIP program memory. It holds the CPU in reset until the image is complete, then releases it. It is the receive-side counterpart of the halt/accumulator transmit path.

---
 rtl/uart_prog_loader_pkg.sv | 17 +
 rtl/uart_prog_loader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    WORD_LO,
    WORD_HI,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 2;
  localparam int CNT_W          = 16;

endpackage

// File: rtl/uart_prog_loader.sv
// UART program loader: assembles a counted frame of 16-bit words into program memory.
// Optional trailing XOR checksum byte enabled with `define UART_PROG_LOADER_CHECKSUM_EN.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int NBITS_D   = 16,
  parameter int ADDR_W    = 11,
  parameter int MAX_WORDS = 2048
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [DBIT-1:0]    i_rx_data,
  input  logic               i_reload,
  output logic               o_mem_we,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [NBITS_D-1:0] o_mem_data,
  output logic               o_cpu_run,
  output logic               o_busy,
  output logic               o_load_done,
  output logic               o_error
);

  localparam int              WORD_W = BYTES_PER_WORD * DBIT;
  localparam logic [CNT_W:0]  MAX_N  = (CNT_W + 1)'(MAX_WORDS);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
  localparam state_t          END_ST = CHECK;
`else
  localparam state_t          END_ST = DONE;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_index;
  logic [DBIT-1:0]     r_lo;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_data;
  logic                r_done;
  logic                r_error;
  logic [CNT_W-1:0]    w_count_full;
  logic [CNT_W-1:0]    w_index_inc;
  logic                w_write;
  logic                w_restart;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
  logic [DBIT-1:0]     r_xor;
`endif

  assign w_count_full = CNT_W'({i_rx_data, r_count[DBIT-1:0]});
  assign w_index_inc  = r_index + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      IDLE:    if (i_rx_done) w_state_next = CNT_HI;
      CNT_HI: begin
        if (i_rx_done) begin
          if ({1'b0, w_count_full} > MAX_N) w_state_next = ERROR;
          else if (w_count_full == '0)      w_state_next = END_ST;
          else                              w_state_next = WORD_LO;
        end
      end
      WORD_LO: if (i_rx_done) w_state_next = WORD_HI;
      WORD_HI: begin
        if (i_rx_done) begin
          w_write      = 1'b1;
          w_state_next = (w_index_inc == r_count) ? END_ST : WORD_LO;
        end
      end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      CHECK:   if (i_rx_done) w_state_next = (i_rx_data == r_xor) ? DONE : ERROR;
`endif
      DONE, ERROR: begin
        // Reload has priority; a byte arriving in the same cycle is dropped.
        if (i_reload) begin
          w_state_next = IDLE;
          w_restart    = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_count    <= '0;
      r_index    <= '0;
      r_lo       <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else begin
      r_mem_we <= w_write;
      r_done   <= (w_state_next == DONE);
      r_error  <= (w_state_next == ERROR);
      if (w_restart) r_index <= '0;
      if (i_rx_done) begin
        case (r_state)
          IDLE:    r_count <= CNT_W'(i_rx_data);
          CNT_HI:  r_count <= w_count_full;
          WORD_LO: r_lo    <= i_rx_data;
          default: ;
        endcase
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        if (r_state == IDLE)
          r_xor <= i_rx_data;
        else if (r_state == CNT_HI || r_state == WORD_LO || r_state == WORD_HI)
          r_xor <= r_xor ^ i_rx_data;
`endif
      end
      if (w_write) begin
        r_mem_addr <= r_index[ADDR_W-1:0];
        r_mem_data <= {i_rx_data, r_lo};
        r_index    <= w_index_inc;
      end
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = NBITS_D'(r_mem_data);
  assign o_cpu_run   = r_done;
  assign o_load_done = r_done;
  assign o_error     = r_error;
  assign o_busy      = (r_state != IDLE) && (r_state != DONE) && (r_state != ERROR);

endmodule
